// File: rtl/miriscv_pkg.sv
// Shared core-wide constants and types used by the fetch-side instruction memory bridge.
package miriscv_pkg;

    localparam int XLEN = 32;

    typedef logic [0:0] imem_bridge_state_t;

    localparam imem_bridge_state_t IMEM_BR_IDLE = 1'b0;
    localparam imem_bridge_state_t IMEM_BR_HOLD = 1'b1;

    // Saturation is not handled here; the checker flags any wrap of the outstanding counters.
    function automatic logic [1:0] imem_cnt_next(input logic [1:0] cnt,
                                                 input logic       inc,
                                                 input logic       dec);
        return cnt + {1'b0, inc} - {1'b0, dec};
    endfunction

endpackage

// File: rtl/miriscv_imem_bridge_if.sv
// Fetch-side and instruction-bus signals of the imem bridge, named from the bridge's point of view.
interface miriscv_imem_bridge_if #(
    parameter int XLEN = miriscv_pkg::XLEN
) ();

    logic            core_req_i;
    logic [XLEN-1:0] core_addr_i;
    logic            core_kill_i;
    logic            core_stall_o;
    logic            core_rvalid_o;
    logic [XLEN-1:0] core_rdata_o;
    logic            core_err_o;
    logic            bus_req_o;
    logic [XLEN-1:0] bus_addr_o;
    logic            bus_gnt_i;
    logic            bus_rvalid_i;
    logic [XLEN-1:0] bus_rdata_i;
    logic            bus_err_i;

    modport slave (
        input  core_req_i, core_addr_i, core_kill_i,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
        output core_stall_o, core_rvalid_o, core_rdata_o, core_err_o,
        output bus_req_o, bus_addr_o
    );

    modport master (
        output core_req_i, core_addr_i, core_kill_i,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
        input  core_stall_o, core_rvalid_o, core_rdata_o, core_err_o,
        input  bus_req_o, bus_addr_o
    );

endinterface

// File: rtl/miriscv_imem_bridge_chk.sv
// Protocol and counter invariants of the imem bridge, instantiated by the bridge itself.
module miriscv_imem_bridge_chk #(
    parameter int XLEN            = miriscv_pkg::XLEN,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic            clk_i,
    input logic            arstn_i,
    input logic            bus_req_o,
    input logic            bus_gnt_i,
    input logic [XLEN-1:0] bus_addr_o,
    input logic            bus_rvalid_i,
    input logic            core_rvalid_o,
    input logic            grant_s,
    input logic [1:0]      cnt_q,
    input logic [1:0]      dcnt_q
);

    localparam logic [1:0] MAX_C = 2'(MAX_OUTSTANDING);

    a_addr_stable: assert property (@(posedge clk_i) disable iff (!arstn_i)
        (bus_req_o && !bus_gnt_i) |=> (bus_req_o && $stable(bus_addr_o)));

    a_cnt_bounds: assert property (@(posedge clk_i) disable iff (!arstn_i)
        (dcnt_q <= cnt_q) && (cnt_q <= MAX_C));

    a_cnt_overflow: assert property (@(posedge clk_i) disable iff (!arstn_i)
        !((cnt_q == MAX_C) && grant_s && !bus_rvalid_i));

    a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!arstn_i)
        !((cnt_q == 2'd0) && bus_rvalid_i));

    a_no_rvalid_in_reset: assert property (@(posedge clk_i)
        !arstn_i |-> !core_rvalid_o);

endmodule

// File: rtl/miriscv_imem_bridge.sv
// Fetch-to-bus bridge: holds ungranted requests, limits outstanding grants and drops
// responses that belong to requests issued before a pipeline kill.
module miriscv_imem_bridge
    import miriscv_pkg::*;
#(
    parameter int XLEN            = miriscv_pkg::XLEN,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    miriscv_imem_bridge_if.slave  br
);

    localparam logic [1:0] MAX_C = 2'(MAX_OUTSTANDING);

    imem_bridge_state_t state_q, state_d;
    logic [XLEN-1:0]    hold_addr_q, hold_addr_d;
    logic               hold_stale_q, hold_stale_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [1:0]         dcnt_q, dcnt_d;

    logic               below_max_s;
    logic               bus_req_s;
    logic [XLEN-1:0]    bus_addr_s;
    logic               stall_s;
    logic               grant_s;
    logic               stale_grant_s;
    logic               rvalid_s;
    logic               drop_s;

    assign below_max_s = (cnt_q < MAX_C);

    // Request path, hold FSM next state and outstanding/discard counter updates.
    always_comb begin
        state_d       = state_q;
        hold_addr_d   = hold_addr_q;
        hold_stale_d  = hold_stale_q;
        bus_req_s     = 1'b0;
        bus_addr_s    = br.core_addr_i;
        stall_s       = 1'b0;
        grant_s       = 1'b0;
        stale_grant_s = 1'b0;

        case (state_q)
            IMEM_BR_IDLE: begin
                if (br.core_req_i && !br.core_kill_i) begin
                    if (below_max_s) begin
                        bus_req_s = 1'b1;
                        if (br.bus_gnt_i) begin
                            grant_s = 1'b1;
                        end else begin
                            hold_addr_d = br.core_addr_i;
                            state_d     = IMEM_BR_HOLD;
                            stall_s     = 1'b1;
                        end
                    end else begin
                        hold_addr_d = br.core_addr_i;
                        state_d     = IMEM_BR_HOLD;
                        stall_s     = 1'b1;
                    end
                end else begin
                    state_d = IMEM_BR_IDLE;
                end
            end
            IMEM_BR_HOLD: begin
                bus_req_s  = below_max_s;
                bus_addr_s = hold_addr_q;
                stall_s    = 1'b1;
                if (below_max_s && br.bus_gnt_i) begin
                    grant_s       = 1'b1;
                    stale_grant_s = hold_stale_q;
                    hold_stale_d  = 1'b0;
                    state_d       = IMEM_BR_IDLE;
                    // The held fetch is accepted on its grant, so the core may advance;
                    // a stale one must not swallow the redirect the core is presenting.
                    stall_s       = hold_stale_q | br.core_kill_i;
                end else if (br.core_kill_i) begin
                    hold_stale_d = 1'b1;
                end else begin
                    hold_stale_d = hold_stale_q;
                end
            end
            default: begin
                state_d = IMEM_BR_IDLE;
            end
        endcase

        rvalid_s = br.bus_rvalid_i && (dcnt_q == 2'd0) && !br.core_kill_i;
        drop_s   = br.bus_rvalid_i && (dcnt_q != 2'd0);
        cnt_d    = imem_cnt_next(cnt_q, grant_s, br.bus_rvalid_i);

        if (br.core_kill_i) begin
            dcnt_d = cnt_d;
        end else begin
            dcnt_d = imem_cnt_next(dcnt_q, stale_grant_s, drop_s);
        end
    end

    // FSM, held request and counters.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q      <= IMEM_BR_IDLE;
            hold_addr_q  <= {XLEN{1'b0}};
            hold_stale_q <= 1'b0;
            cnt_q        <= 2'd0;
            dcnt_q       <= 2'd0;
        end else begin
            state_q      <= state_d;
            hold_addr_q  <= hold_addr_d;
            hold_stale_q <= hold_stale_d;
            cnt_q        <= cnt_d;
            dcnt_q       <= dcnt_d;
        end
    end

    assign br.bus_req_o     = arstn_i & bus_req_s;
    assign br.bus_addr_o    = bus_addr_s;
    assign br.core_stall_o  = arstn_i & stall_s;
    assign br.core_rvalid_o = arstn_i & rvalid_s;
    assign br.core_rdata_o  = br.bus_rdata_i;
    assign br.core_err_o    = arstn_i & rvalid_s & br.bus_err_i;

    miriscv_imem_bridge_chk #(
        .XLEN            (XLEN),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_chk (
        .clk_i         (clk_i),
        .arstn_i       (arstn_i),
        .bus_req_o     (br.bus_req_o),
        .bus_gnt_i     (br.bus_gnt_i),
        .bus_addr_o    (br.bus_addr_o),
        .bus_rvalid_i  (br.bus_rvalid_i),
        .core_rvalid_o (br.core_rvalid_o),
        .grant_s       (grant_s),
        .cnt_q         (cnt_q),
        .dcnt_q        (dcnt_q)
    );

endmodule

// File: tb/tb_miriscv_imem_bridge.sv
// Scoreboard bench for the imem bridge: a latency-configurable bus model answers grants,
// accepted fetches queue their expected words and every delivered word is popped and compared.
module tb_miriscv_imem_bridge;

    logic clk;
    logic arstn;

    miriscv_imem_bridge_if bif ();

    miriscv_imem_bridge #(
        .XLEN            (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .br      (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // bus model: responses owed, in grant order
    logic [31:0] bq_data[$];
    logic        bq_err[$];
    int          bq_due[$];
    // scoreboard: words the core expects, in acceptance order
    logic [31:0] sb_data[$];
    logic        sb_err[$];
    int          sb_cyc[$];

    int   cyc        = 0;
    int   lat        = 1;
    int   gnt_block  = 0;
    logic err_next   = 1'b0;
    logic lat_chk    = 1'b0;
    logic [31:0] exp_hold_addr = 32'h0;

    int n_stall, n_stall_noreq, n_gnt, n_bus_rv, n_deliv, n_wait, n_addr_bad, max_out;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clr_stats();
        n_stall = 0; n_stall_noreq = 0; n_gnt = 0; n_bus_rv = 0;
        n_deliv = 0; n_wait = 0; n_addr_bad = 0; max_out = 0;
    endtask

    // One clock: drive bus inputs, sample at the falling edge, then advance past the rising edge.
    task automatic cycle(output bit acc);
        acc = 1'b0;
        bif.bus_gnt_i = (gnt_block == 0);
        if (bq_due.size() > 0 && bq_due[0] <= cyc) begin
            bif.bus_rvalid_i = 1'b1;
            bif.bus_rdata_i  = bq_data[0];
            bif.bus_err_i    = bq_err[0];
        end else begin
            bif.bus_rvalid_i = 1'b0;
            bif.bus_rdata_i  = 32'h0;
            bif.bus_err_i    = 1'b0;
        end
        #4;
        if (bif.core_stall_o) n_stall++;
        if (bif.core_stall_o && !bif.bus_req_o) n_stall_noreq++;
        if (bif.bus_req_o && !bif.bus_gnt_i) begin
            n_wait++;
            if (bif.bus_addr_o !== exp_hold_addr) n_addr_bad++;
        end
        if (bif.bus_rvalid_i) begin
            void'(bq_data.pop_front());
            void'(bq_err.pop_front());
            void'(bq_due.pop_front());
            n_bus_rv++;
        end
        if (bif.bus_req_o && bif.bus_gnt_i) begin
            bq_data.push_back(mem_word(bif.bus_addr_o));
            bq_err.push_back(err_next);
            bq_due.push_back(cyc + lat);
            n_gnt++;
        end
        if (bq_due.size() > max_out) max_out = bq_due.size();
        if (bif.core_rvalid_o) begin
            n_deliv++;
            if (sb_data.size() == 0) begin
                check_val("unexpected_rvalid", 32'(bif.core_rdata_o), 32'hFFFF_FFFF);
            end else begin
                check_val("rdata", bif.core_rdata_o, sb_data.pop_front());
                check_val("err", 32'(bif.core_err_o), 32'(sb_err.pop_front()));
                if (lat_chk) check_val("latency", 32'(cyc - sb_cyc[0]), 32'd1);
                void'(sb_cyc.pop_front());
            end
        end
        if (bif.core_kill_i) begin
            sb_data.delete(); sb_err.delete(); sb_cyc.delete();
        end else if (bif.core_req_i && !bif.core_stall_o) begin
            sb_data.push_back(mem_word(bif.core_addr_i));
            sb_err.push_back(err_next);
            sb_cyc.push_back(cyc);
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (gnt_block > 0) gnt_block--;
    endtask

    task automatic issue(input logic [31:0] a);
        bit acc;
        acc = 1'b0;
        bif.core_req_i  = 1'b1;
        bif.core_addr_i = a;
        bif.core_kill_i = 1'b0;
        exp_hold_addr   = a;
        for (int i = 0; i < 40; i++) begin
            cycle(acc);
            if (acc) break;
        end
        check_val("issue_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        bit acc;
        bif.core_req_i = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (sb_data.size() == 0 && bq_due.size() == 0) break;
            cycle(acc);
        end
        check_val("drain_sb", 32'(sb_data.size()), 32'd0);
        check_val("drain_bus", 32'(bq_due.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        arstn = 1'b0;
        bif.core_req_i = 1'b1; bif.core_addr_i = 32'h0; bif.core_kill_i = 1'b0;
        bif.bus_gnt_i = 1'b1; bif.bus_rvalid_i = 1'b1; bif.bus_rdata_i = 32'h0; bif.bus_err_i = 1'b1;
        #2;
        check_val("rst_bus_req", 32'(bif.bus_req_o), 32'd0);
        check_val("rst_stall", 32'(bif.core_stall_o), 32'd0);
        check_val("rst_rvalid", 32'(bif.core_rvalid_o), 32'd0);
        check_val("rst_err", 32'(bif.core_err_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        bif.core_req_i = 1'b0; bif.bus_rvalid_i = 1'b0; bif.bus_err_i = 1'b0;
        arstn = 1'b1;
        clr_stats();
        cycle(acc);
        check_val("idle_no_req", 32'(n_gnt), 32'd0);
        check_val("idle_no_stall", 32'(n_stall), 32'd0);

        // zero-wait bus, back-to-back fetches
        clr_stats(); lat = 1; lat_chk = 1'b1;
        issue(32'h0); issue(32'h4); issue(32'h8);
        drain();
        lat_chk = 1'b0;
        check_val("zw_stall", 32'(n_stall), 32'd0);
        check_val("zw_deliv", 32'(n_deliv), 32'd3);
        check_val("zw_gnt", 32'(n_gnt), 32'd3);

        // grant delayed three cycles
        clr_stats(); lat = 1; gnt_block = 3;
        issue(32'h100);
        drain();
        check_val("gd_stall", 32'(n_stall), 32'd3);
        check_val("gd_wait", 32'(n_wait), 32'd3);
        check_val("gd_addr_stable", 32'(n_addr_bad), 32'd0);
        check_val("gd_gnt", 32'(n_gnt), 32'd1);
        check_val("gd_deliv", 32'(n_deliv), 32'd1);

        // outstanding limit with slow responses
        clr_stats(); lat = 4;
        issue(32'h10); issue(32'h14); issue(32'h18);
        drain();
        check_val("max_noreq_stall", 32'(n_stall_noreq), 32'd3);
        check_val("max_outstanding", 32'(max_out), 32'd2);
        check_val("max_deliv", 32'(n_deliv), 32'd3);

        // kill with two requests in flight, redirect to 0x200
        clr_stats(); lat = 4;
        issue(32'h20); issue(32'h24);
        bif.core_addr_i = 32'h9990; bif.core_kill_i = 1'b1;
        cycle(acc);
        check_val("kill_req_ignored", 32'(acc), 32'd0);
        bif.core_kill_i = 1'b0;
        issue(32'h200);
        drain();
        check_val("kill_deliv", 32'(n_deliv), 32'd1);
        check_val("kill_dropped", 32'(n_bus_rv - n_deliv), 32'd2);
        check_val("kill_gnt", 32'(n_gnt), 32'd3);

        // kill while holding 0x300, redirect to 0x400
        clr_stats(); lat = 1; gnt_block = 3;
        bif.core_req_i = 1'b1; bif.core_addr_i = 32'h300; bif.core_kill_i = 1'b0;
        exp_hold_addr = 32'h300;
        cycle(acc);
        check_val("hold_stalled", 32'(acc), 32'd0);
        bif.core_addr_i = 32'h400; bif.core_kill_i = 1'b1;
        cycle(acc);
        check_val("hold_kill_ignored", 32'(acc), 32'd0);
        bif.core_kill_i = 1'b0;
        bif.core_req_i  = 1'b1;
        bif.core_addr_i = 32'h400;
        for (int i = 0; i < 40; i++) begin
            cycle(acc);
            if (acc) break;
        end
        check_val("hold_redirect_acc", 32'(acc), 32'd1);
        drain();
        check_val("hold_gnt", 32'(n_gnt), 32'd2);
        check_val("hold_bus_rv", 32'(n_bus_rv), 32'd2);
        check_val("hold_deliv", 32'(n_deliv), 32'd1);

        // bus error propagation
        clr_stats(); lat = 2; err_next = 1'b1;
        issue(32'h500);
        err_next = 1'b0;
        issue(32'h504);
        drain();
        check_val("err_deliv", 32'(n_deliv), 32'd2);

        // asynchronous reset mid-burst
        clr_stats(); lat = 4;
        issue(32'h600); issue(32'h604);
        bif.core_addr_i = 32'h608;
        cycle(acc);
        #2;
        arstn = 1'b0;
        bif.bus_rvalid_i = 1'b1; bif.bus_err_i = 1'b1; bif.bus_gnt_i = 1'b1;
        #1;
        check_val("mid_rst_bus_req", 32'(bif.bus_req_o), 32'd0);
        check_val("mid_rst_stall", 32'(bif.core_stall_o), 32'd0);
        check_val("mid_rst_rvalid", 32'(bif.core_rvalid_o), 32'd0);
        check_val("mid_rst_err", 32'(bif.core_err_o), 32'd0);
        bq_data.delete(); bq_err.delete(); bq_due.delete();
        sb_data.delete(); sb_err.delete(); sb_cyc.delete();
        bif.core_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bif.bus_rvalid_i = 1'b0; bif.bus_err_i = 1'b0;
        arstn = 1'b1;
        clr_stats(); lat = 4;
        issue(32'h700); issue(32'h704);
        check_val("post_rst_stall", 32'(n_stall), 32'd0);
        drain();
        check_val("post_rst_deliv", 32'(n_deliv), 32'd2);
        check_val("post_rst_dropped", 32'(n_bus_rv - n_deliv), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
